// File: rtl/dm_pkg.sv
// Shared encodings for the MEM-stage data-memory port.
// Holds the store/load type codes, the responder FSM state type and
// the largest supported wait-state count.
package dm_pkg;

  // Store type (w_dm)
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_SB   = 2'b01;
  localparam logic [1:0] W_SH   = 2'b10;
  localparam logic [1:0] W_SW   = 2'b11;

  // Load type (r_dm); 3'd6 and 3'd7 behave as no load
  localparam logic [2:0] R_NONE = 3'd0;
  localparam logic [2:0] R_LB   = 3'd1;
  localparam logic [2:0] R_LH   = 3'd2;
  localparam logic [2:0] R_LW   = 3'd3;
  localparam logic [2:0] R_LBU  = 3'd4;
  localparam logic [2:0] R_LHU  = 3'd5;

  // Responder FSM state
  typedef logic [1:0] dm_state_t;
  localparam dm_state_t ST_IDLE = 2'd0;
  localparam dm_state_t ST_WAIT = 2'd1;
  localparam dm_state_t ST_RESP = 2'd2;

  // Wait-state counter is 4 bits wide
  localparam int unsigned WAIT_CYCLES_MAX = 15;

  function automatic logic load_valid(input logic [2:0] r);
    return (r >= R_LB) && (r <= R_LHU);
  endfunction

endpackage

// File: rtl/dm_wait_responder_if.sv
// MEM-stage load/store port between the pipeline and the data memory.
//   addr, wdata, w_dm, r_dm : request, driven by the pipeline (master)
//   rdata, busy, ready, misaligned : response, driven by the memory (slave)
interface dm_wait_responder_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  w_dm;
  logic [2:0]  r_dm;
  logic [31:0] rdata;
  logic        busy;
  logic        ready;
  logic        misaligned;

  modport master (
    output addr, wdata, w_dm, r_dm,
    input  rdata, busy, ready, misaligned
  );

  modport slave (
    input  addr, wdata, w_dm, r_dm,
    output rdata, busy, ready, misaligned
  );
endinterface

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the data memory.
//   w_type_i, r_type_i : latched store / load type
//   off_i              : byte offset addr[1:0]
//   wdata_i, rword_i   : store data, word read from the array
//   be_c_o, wdata_c_o  : per-byte write enables and lane-replicated store data
//   rdata_c_o          : selected and extended load result
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  w_type_i,
  input  logic [2:0]  r_type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_c_o,
  output logic [31:0] wdata_c_o,
  output logic [31:0] rdata_c_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Store path: replicate data across lanes, enable only the addressed ones
  always_comb begin
    be_c_o    = 4'b0000;
    wdata_c_o = wdata_i;
    case (w_type_i)
      W_SB: begin
        be_c_o    = 4'b0001 << off_i;
        wdata_c_o = {4{wdata_i[7:0]}};
      end
      W_SH: begin
        be_c_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_c_o = {2{wdata_i[15:0]}};
      end
      W_SW:    be_c_o = 4'b1111;
      default: be_c_o = 4'b0000;
    endcase
  end

  // Load path: pick the addressed lane, then sign- or zero-extend
  always_comb begin
    case (off_i)
      2'd0:    rbyte = rword_i[7:0];
      2'd1:    rbyte = rword_i[15:8];
      2'd2:    rbyte = rword_i[23:16];
      default: rbyte = rword_i[31:24];
    endcase
    rhalf = off_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (r_type_i)
      R_LB:    rdata_c_o = {{24{rbyte[7]}}, rbyte};
      R_LH:    rdata_c_o = {{16{rhalf[15]}}, rhalf};
      R_LW:    rdata_c_o = rword_i;
      R_LBU:   rdata_c_o = {24'd0, rbyte};
      R_LHU:   rdata_c_o = {16'd0, rhalf};
      default: rdata_c_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/dm_wait_responder.sv
// Multi-cycle data-memory responder with programmable wait states.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : slave side of the MEM-stage port (request in; rdata,
//                busy, ready, misaligned out). busy is combinational,
//                the others are registered.
module dm_wait_responder
  import dm_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  dm_wait_responder_if.slave bus
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned LAW       = AW + 2;
  localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
  localparam logic [3:0]  CNT_LOAD  = 4'(WAIT_LOAD);

  dm_state_t       state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [LAW-1:0]  addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      w_type_q, w_type_d;
  logic [2:0]      r_type_q, r_type_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            mis_q, mis_d;
  logic            mem_we;

  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [AW-1:0]   word_idx;
  logic [31:0]     rword;
  logic [3:0]      be;
  logic [31:0]     wdata_sh;
  logic [31:0]     rdata_ext;

  logic            req_store, req_load, req_valid, req_half, req_word, req_mis;
  logic [2:0]      req_r_type;

  // Upper address bits only alias the array
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[31:LAW];

  // Request decode; a store takes precedence over a simultaneous load
  always_comb begin
    req_store  = (bus.w_dm != W_NONE);
    req_load   = load_valid(bus.r_dm);
    req_valid  = req_store || req_load;
    req_r_type = (req_store || !req_load) ? R_NONE : bus.r_dm;
    req_half   = req_store ? (bus.w_dm == W_SH) : ((req_r_type == R_LH) || (req_r_type == R_LHU));
    req_word   = req_store ? (bus.w_dm == W_SW) : (req_r_type == R_LW);
    req_mis    = (req_half && bus.addr[0]) || (req_word && (bus.addr[1:0] != 2'b00));
  end

  assign word_idx = addr_q[LAW-1:2];
  assign rword    = mem_q[word_idx];

  dm_lane_align u_lane_align (
    .w_type_i  (w_type_q),
    .r_type_i  (r_type_q),
    .off_i     (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rword_i   (rword),
    .be_c_o    (be),
    .wdata_c_o (wdata_sh),
    .rdata_c_o (rdata_ext)
  );

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    w_type_d = w_type_q;
    r_type_d = r_type_q;
    rdata_d  = rdata_q;
    ready_d  = 1'b0;
    mis_d    = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_mis) begin
            // Rejected without touching the array
            rdata_d = 32'd0;
            ready_d = 1'b1;
            mis_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            addr_d   = bus.addr[LAW-1:0];
            wdata_d  = bus.wdata;
            w_type_d = bus.w_dm;
            r_type_d = req_r_type;
            cnt_d    = CNT_LOAD;
            state_d  = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mem_we  = (w_type_q != W_NONE);
          if (r_type_q != R_NONE) rdata_d = rdata_ext;
          ready_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      w_type_q <= W_NONE;
      r_type_q <= R_NONE;
      rdata_q  <= 32'd0;
      ready_q  <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      w_type_q <= w_type_d;
      r_type_q <= r_type_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      mis_q    <= mis_d;
    end
  end

  // Storage array keeps its contents across reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  // Stall while a request is being accepted or is in flight; quiet during reset
  assign bus.busy       = !reset && (((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT));
  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_q;
  assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_dm_wait_responder.sv
// Scoreboard bench for dm_wait_responder: a byte-addressed reference
// memory predicts each response, a monitor compares on every ready pulse.
module tb_dm_wait_responder;

  localparam int unsigned DW        = 256;
  localparam int unsigned WC        = 2;
  localparam int unsigned MEM_BYTES = DW * 4;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          lat;
    int          start;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t        q[$];
  exp_t        mon_e;
  logic [7:0]  mem_b [MEM_BYTES];
  logic [31:0] m_rdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_wait_responder_if bus();

  dm_wait_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int acc_size(input logic [1:0] w, input logic [2:0] r);
    if (w != 2'd0) return (w == 2'd1) ? 1 : ((w == 2'd2) ? 2 : 4);
    if (r == 3'd1 || r == 3'd4) return 1;
    if (r == 3'd2 || r == 3'd5) return 2;
    return 4;
  endfunction

  // Predict, enqueue, then drive one request; returns at posedge+1 of an idle cycle
  task automatic access(input logic [1:0] w, input logic [2:0] r, input logic [31:0] a,
                        input logic [31:0] d, input bit scramble);
    exp_t e;
    int sz, base, n;
    bit st, mis, done;
    longint unsigned v;
    st   = (w != 2'd0);
    sz   = acc_size(w, r);
    mis  = (int'(a[1:0]) % sz) != 0;
    base = int'(a[9:0]);
    if (mis) m_rdata = 32'd0;
    else if (st) begin
      for (int i = 0; i < sz; i++) mem_b[(base + i) % MEM_BYTES] = 8'(d >> (8 * i));
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (64'(mem_b[(base + i) % MEM_BYTES]) << (8 * i));
      if ((r == 3'd1 || r == 3'd2) && v[8 * sz - 1]) v = v - (64'd1 << (8 * sz));
      m_rdata = 32'(v);
    end
    e.rdata = m_rdata;
    e.mis   = mis;
    e.lat   = mis ? 1 : int'(WC) + 2;
    e.start = cyc;
    q.push_back(e);
    bus.addr = a; bus.wdata = d; bus.w_dm = w; bus.r_dm = r;
    n = 0; done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.busy) begin
        n++;
        @(posedge clk); #1;
        if (scramble) begin
          bus.addr = $urandom; bus.wdata = $urandom;
          bus.w_dm = 2'($urandom); bus.r_dm = 3'($urandom);
        end
      end else done = 1;
    end
    check("busy_cycles", 32'(n), 32'(e.lat));
    @(posedge clk); #1;
    bus.w_dm = 2'd0; bus.r_dm = 3'd0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_ready"}, 32'(bus.ready), 32'd0);
    check({tag, "_misaligned"}, 32'(bus.misaligned), 32'd0);
    check({tag, "_rdata"}, bus.rdata, 32'd0);
  endtask

  // Monitor: every ready pulse must match the oldest predicted response
  always @(negedge clk) begin
    if (!reset && bus.ready) begin
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_ready: ready=1 with nothing outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = q.pop_front();
        check("rdata", bus.rdata, mon_e.rdata);
        check("misaligned", 32'(bus.misaligned), 32'(mon_e.mis));
        check("ready_latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
      end
    end else if (!reset && bus.misaligned) begin
      n_cmp++; n_bad++;
      $display("FAIL misaligned_without_ready: got 1, required 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [1:0] w;
    logic [2:0] r;
    reset = 1'b1;
    bus.addr = 32'd0; bus.wdata = 32'd0; bus.w_dm = 2'd0; bus.r_dm = 3'd0;
    m_rdata = 32'd0;
    @(negedge clk);
    check_quiet("reset");
    bus.w_dm = 2'd3;  // request present during reset must not raise busy
    @(negedge clk);
    check_quiet("reset_req");
    bus.w_dm = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;

    // Give every word a known value
    for (int i = 0; i < int'(DW); i++) access(2'd3, 3'd0, 32'(i * 4), $urandom, 1'b0);

    access(2'd3, 3'd0, 32'h10, 32'hDEADBEEF, 1'b0);
    access(2'd0, 3'd3, 32'h10, 32'h0, 1'b0);
    check("lw_deadbeef", bus.rdata, 32'hDEADBEEF);

    access(2'd3, 3'd0, 32'h10, 32'h80FF7F01, 1'b0);
    access(2'd0, 3'd1, 32'h13, 32'h0, 1'b0);
    check("lb_0x13", bus.rdata, 32'hFFFFFF80);
    access(2'd0, 3'd4, 32'h13, 32'h0, 1'b0);
    check("lbu_0x13", bus.rdata, 32'h00000080);
    access(2'd0, 3'd2, 32'h10, 32'h0, 1'b0);
    check("lh_0x10", bus.rdata, 32'h00007F01);
    access(2'd0, 3'd5, 32'h12, 32'h0, 1'b0);
    check("lhu_0x12", bus.rdata, 32'h000080FF);

    access(2'd3, 3'd0, 32'h10, 32'h0, 1'b0);
    access(2'd1, 3'd0, 32'h11, 32'hAA, 1'b0);
    access(2'd0, 3'd3, 32'h10, 32'h0, 1'b0);
    check("sb_then_lw", bus.rdata, 32'h0000AA00);
    access(2'd2, 3'd0, 32'h12, 32'h1234, 1'b0);
    access(2'd0, 3'd3, 32'h10, 32'h0, 1'b0);
    check("sh_then_lw", bus.rdata, 32'h1234AA00);

    access(2'd0, 3'd3, 32'h11, 32'h0, 1'b0);
    check("misaligned_lw_rdata", bus.rdata, 32'h0);
    access(2'd2, 3'd0, 32'h13, 32'hFFFF, 1'b0);
    access(2'd0, 3'd3, 32'h10, 32'h0, 1'b0);
    check("mem_after_misaligned", bus.rdata, 32'h1234AA00);

    access(2'd3, 3'd0, 32'h0, 32'hCAFEF00D, 1'b0);
    access(2'd0, 3'd3, 32'h400, 32'h0, 1'b0);
    check("wrap_0x400", bus.rdata, 32'hCAFEF00D);
    access(2'd3, 3'd3, 32'h14, 32'h11112222, 1'b0);
    check("store_wins_rdata_held", bus.rdata, 32'hCAFEF00D);
    access(2'd0, 3'd3, 32'h14, 32'h0, 1'b0);
    check("store_wins_written", bus.rdata, 32'h11112222);

    // Reset two cycles into a store aborts it
    bus.addr = 32'h20; bus.wdata = 32'h55; bus.w_dm = 2'd3; bus.r_dm = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_quiet("reset_in_wait");
    bus.w_dm = 2'd0;
    @(negedge clk);
    check_quiet("reset_in_wait_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    m_rdata = 32'd0;
    access(2'd0, 3'd3, 32'h20, 32'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      w = $urandom_range(0, 1) ? 2'($urandom_range(1, 3)) : 2'd0;
      r = 3'($urandom_range(0, 7));
      if (w == 2'd0 && (r == 3'd0 || r > 3'd5)) r = 3'($urandom_range(1, 5));
      access(w, r, 32'($urandom_range(0, 4095)), $urandom, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
